// File: rtl/fp16_mult_result_buffer.sv
// fp16_mult_result_buffer
//   Elastic result stage behind the combinational FP16 multiplier. Each
//   accepted product is classified on entry and queued together with its
//   class in a DEPTH-entry FIFO. Sticky exception flags and a saturating
//   NaN counter feed the FPU status path.
//
//   Optional build macro: FP16_RESBUF_BYPASS_EN
//     When defined, an empty buffer presents the incoming product
//     combinationally on the output. If the consumer takes it in the same
//     cycle, the product skips storage and latency is zero.
//     When undefined, there is no combinational path from input to output.

module fp16_mult_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [15:0]                  in_product,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_product,
    output logic [2:0]                   out_class,
    input  logic                         flag_clr,
    output logic                         sticky_nan,
    output logic                         sticky_inf,
    output logic                         sticky_uf,
    output logic [CNT_W-1:0]             nan_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } fp_class_e;

    // The sign bit never affects the class, so only exponent and mantissa are passed in.
    function automatic fp_class_e classify(input logic [4:0] exp_f, input logic [9:0] mant_f);
        fp_class_e cls;
        if (exp_f == 5'h1F) begin
            if (mant_f == 10'd0)  cls = CLS_INF;
            else if (mant_f[9])   cls = CLS_QNAN;
            else                  cls = CLS_SNAN;
        end else if (exp_f == 5'd0) begin
            cls = (mant_f == 10'd0) ? CLS_ZERO : CLS_SUB;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

    // Each entry holds {class, product}.
    logic [18:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    fp_class_e  in_class;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       store;
    logic       pop_store;
    logic       push_nan;
    logic       push_inf;
    logic       push_uf;
    logic [18:0] head;

    assign in_class = classify(in_product[14:10], in_product[9:0]);
    assign empty    = (count == '0);
    assign full     = (count == OCC_W'(DEPTH));
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign head     = mem[rd_ptr];

    // A pop only dequeues storage when something is actually stored.
    assign pop_store = pop & ~empty;

`ifdef FP16_RESBUF_BYPASS_EN
    // An empty buffer forwards the incoming product. If the consumer takes
    // it in the same cycle, it is never written into storage.
    assign store       = push & ~(empty & out_ready);
    assign out_valid   = ~empty | (in_valid & ~rst);
    assign out_product = ~empty ? head[15:0] : (rst ? 16'd0 : in_product);
    assign out_class   = ~empty ? head[18:16] : (rst ? 3'd0 : in_class);
`else
    // Outputs read zero while empty, so they are defined straight out of reset.
    assign store       = push;
    assign out_valid   = ~empty;
    assign out_product = empty ? 16'd0 : head[15:0];
    assign out_class   = empty ? 3'd0 : head[18:16];
`endif

    assign push_nan = push & ((in_class == CLS_QNAN) | (in_class == CLS_SNAN));
    assign push_inf = push & (in_class == CLS_INF);
    assign push_uf  = push & ((in_class == CLS_ZERO) | (in_class == CLS_SUB));

    // Storage write port.
    // NOTE: the data array has no reset; valid/empty tracking comes from count,
    // so stale contents are never observable and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= {in_class, in_product};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_store) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({store, pop_store})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags and the NaN counter. A flagged push beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_nan <= 1'b0;
            sticky_inf <= 1'b0;
            sticky_uf  <= 1'b0;
            nan_cnt    <= '0;
        end else begin
            sticky_nan <= (sticky_nan & ~flag_clr) | push_nan;
            sticky_inf <= (sticky_inf & ~flag_clr) | push_inf;
            sticky_uf  <= (sticky_uf  & ~flag_clr) | push_uf;
            if (flag_clr) begin
                nan_cnt <= push_nan ? CNT_W'(1) : '0;
            end else if (push_nan && (nan_cnt != '1)) begin
                nan_cnt <= nan_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp16_mult_result_buffer.sv
// Self-checking bench for fp16_mult_result_buffer (DEPTH=4, CNT_W=2).
// The reference model is a queue of products plus flag bits. Classes are
// derived arithmetically from the exponent and mantissa fields.
// Bypass-specific expectations follow FP16_RESBUF_BYPASS_EN.

module tb_fp16_mult_result_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int OCC_W = $clog2(DEPTH + 1);
`ifdef FP16_RESBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_product;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_product;
    logic [2:0]        out_class;
    logic              flag_clr;
    logic              sticky_nan;
    logic              sticky_inf;
    logic              sticky_uf;
    logic [CNT_W-1:0]  nan_cnt;
    logic [OCC_W-1:0]  count;

    fp16_mult_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_class(out_class),
        .flag_clr(flag_clr),
        .sticky_nan(sticky_nan), .sticky_inf(sticky_inf), .sticky_uf(sticky_uf),
        .nan_cnt(nan_cnt), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [15:0] q[$];
    bit          m_nan, m_inf, m_uf;
    int          m_cnt;
    int          max_cnt = (1 << CNT_W) - 1;

    function automatic int ref_class(input logic [15:0] p);
        int e = (int'(p) / 1024) % 32;
        int m = int'(p) % 1024;
        if (e == 31) begin
            if (m == 0)   return 3;
            if (m >= 512) return 4;
            return 5;
        end
        if (e == 0) return (m == 0) ? 0 : 1;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic        e_valid;
        logic [15:0] e_prod;
        int          e_cls;
        if (q.size() > 0) begin
            e_valid = 1'b1;
            e_prod  = q[0];
            e_cls   = ref_class(q[0]);
        end else if (BYP && !rst) begin
            e_valid = in_valid;
            e_prod  = in_product;
            e_cls   = ref_class(in_product);
        end else begin
            e_valid = 1'b0;
            e_prod  = 16'd0;
            e_cls   = 0;
        end
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".in_ready"},  32'(in_ready),  32'((!rst && q.size() < DEPTH) ? 1 : 0));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        if (e_valid) begin
            check({tag, ".out_product"}, 32'(out_product), 32'(e_prod));
            check({tag, ".out_class"},   32'(out_class),   32'(e_cls));
        end
        check({tag, ".flags"},   32'({sticky_nan, sticky_inf, sticky_uf}), 32'({m_nan, m_inf, m_uf}));
        check({tag, ".nan_cnt"}, 32'(nan_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic ordy, input logic clr);
        in_valid   = v;
        in_product = p;
        out_ready  = ordy;
        flag_clr   = clr;
    endtask

    // One clock: predict the handshake from pre-edge inputs, then update the model.
    task automatic step(input string tag);
        bit          push, pop, skip;
        int          cls;
        logic [15:0] prod;
        push = !rst && in_valid && (q.size() < DEPTH);
        pop  = !rst && out_ready && ((q.size() > 0) || (BYP && in_valid));
        skip = BYP && (q.size() == 0) && push && out_ready;
        prod = in_product;
        cls  = ref_class(in_product);
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_nan = 0; m_inf = 0; m_uf = 0; m_cnt = 0;
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push && !skip) q.push_back(prod);
            if (flag_clr) begin
                m_nan = 0; m_inf = 0; m_uf = 0; m_cnt = 0;
            end
            if (push) begin
                if (cls == 4 || cls == 5) begin
                    m_nan = 1;
                    if (m_cnt < max_cnt) m_cnt++;
                end
                if (cls == 3) m_inf = 1;
                if (cls <= 1) m_uf = 1;
            end
        end
        check_state(tag);
    endtask

    logic [15:0] specials [8] = '{16'hFFFF, 16'hFDFF, 16'h7C00, 16'hFC00,
                                  16'h0000, 16'h8000, 16'h0001, 16'h7E00};

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        q.delete();
        m_nan = 0; m_inf = 0; m_uf = 0; m_cnt = 0;

        // Reset.
        step("rst0");
        step("rst1");
        check("rst_in_ready_low", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_high", 32'(in_ready), 1);
        check_state("after_rst");

        // Single product pass-through.
        drive(1'b1, 16'h3C00, 1'b1, 1'b0);
        step("t1_push");
        check("t1_valid", 32'(out_valid), 1);
        check("t1_prod", 32'(out_product), 32'h3C00);
        check("t1_cls", 32'(out_class), 2);
        check("t1_flags", 32'({sticky_nan, sticky_inf, sticky_uf}), 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        step("t1_pop");
        check("t1_count", 32'(count), 0);

        // Fill to full with out_ready low, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0);
            step("t2_fill");
        end
        drive(1'b1, 16'h0005, 1'b0, 1'b0);
        step("t2_full");
        check("t2_in_ready", 32'(in_ready), 0);
        check("t2_count", 32'(count), DEPTH);
        check("t2_cls", 32'(out_class), 1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("t2_drain", 32'(out_product), i);
            step("t2_pop");
        end
        // Second fill exercises pointer wrap.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
            step("t2_refill");
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            check("t2_wrap", 32'(out_product), 32'h10 + i);
            step("t2_repop");
        end

        // Special encodings and sticky flags.
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step("t3_clr");
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0); step("t3_qnan");
        drive(1'b1, 16'hFDFF, 1'b0, 1'b0); step("t3_snan");
        drive(1'b1, 16'h7C00, 1'b0, 1'b0); step("t3_inf");
        drive(1'b1, 16'h0000, 1'b0, 1'b0); step("t3_zero");
        check("t3_flags", 32'({sticky_nan, sticky_inf, sticky_uf}), 32'b111);
        check("t3_nan_cnt", 32'(nan_cnt), 2);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3_cls_q", 32'(out_class), 4); step("t3_pop0");
        check("t3_cls_s", 32'(out_class), 5); step("t3_pop1");
        check("t3_cls_i", 32'(out_class), 3); step("t3_pop2");
        check("t3_cls_z", 32'(out_class), 0); step("t3_pop3");

        // Clear coinciding with a NaN push: the push wins.
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1);
        step("t4_clr_push");
        check("t4_nan", 32'(sticky_nan), 1);
        check("t4_cnt", 32'(nan_cnt), 1);
        check("t4_inf", 32'(sticky_inf), 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        step("t4_drain");

        // NaN counter saturation.
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        step("t5_clr");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i % 2 == 0) ? 16'h7E01 : 16'h7C01, 1'b1, 1'b0);
            step("t5_nan");
        end
        check("t5_sat", 32'(nan_cnt), 3);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        step("t5_drain");

        // Reset mid-operation discards stored entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
            step("t6_fill");
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        step("t6_rst");
        rst = 1'b0;
        #1;
        check("t6_count", 32'(count), 0);
        check("t6_valid", 32'(out_valid), 0);
        check("t6_ready", 32'(in_ready), 1);

`ifdef FP16_RESBUF_BYPASS_EN
        // Zero-latency bypass when empty.
        drive(1'b1, 16'h4500, 1'b1, 1'b0);
        #1;
        check("byp_valid", 32'(out_valid), 1);
        check("byp_prod", 32'(out_product), 32'h4500);
        check("byp_cls", 32'(out_class), 2);
        step("byp_take");
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        step("byp_idle");
        check("byp_count", 32'(count), 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] p;
            p = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
            drive(1'($urandom_range(0, 3) != 0), p,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_mult_result_buffer.md
# fp16_mult_result_buffer

Elastic result stage directly downstream of the combinational half-precision multiplier. Accepts one 16-bit product per cycle over a valid/ready handshake, classifies it (zero, subnormal, normal, inf, qNaN, sNaN), and buffers it in a DEPTH-entry FIFO for the consumer. Maintains sticky exception flags and a saturating NaN counter for the FPU status path.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2
- CNT_W, 16: width of the NaN event counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  multiplier product valid
- in_ready  out  1  buffer can accept
- in_product  in  16  product {sign, exp[4:0], mant[9:0]}
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_product  out  16  head product
- out_class  out  3  head class: 0 ZERO, 1 SUB, 2 NORM, 3 INF, 4 QNAN, 5 SNAN
- flag_clr  in  1  clear sticky flags and NaN counter
- sticky_nan  out  1  any accepted QNAN/SNAN since clear
- sticky_inf  out  1  any accepted INF since clear
- sticky_uf  out  1  any accepted ZERO/SUB since clear
- nan_cnt  out  CNT_W  accepted NaN count, saturating
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Classification of in_product (sign ignored): exp==5'h1F & mant==0 → INF; exp==5'h1F & mant[9] → QNAN; exp==5'h1F & ~mant[9] & mant!=0 → SNAN; exp==0 & mant==0 → ZERO; exp==0 & mant!=0 → SUB; else NORM. Class computed on entry, stored beside the product (FIFO entry 19 bits).
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~rst. No write-through when full; simultaneous push and pop when full is impossible (in_ready low).
- Push+pop same cycle with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty from count.
- Flags and nan_cnt update on every push only (never on pop).
- nan_cnt increments on QNAN/SNAN push; holds at 2^CNT_W−1.
- flag_clr clears flags and nan_cnt; a flagged push in the same cycle wins: flag ends set, nan_cnt ends 1.
- Classification of the multiplier's overflow/NaN encodings: 16'hFFFF → QNAN, 16'hFDFF → SNAN, 16'h7C00/16'hFC00 → INF.

## Timing
- Reset (rst high at clk edge): count=0, pointers=0, out_valid=0, out_product=0, out_class=0, all sticky flags=0, nan_cnt=0; in_ready=0 while rst high, 1 on the first cycle after.
- Reset mid-operation discards all stored entries; pending out_valid drops next cycle.
- Latency (default build): push in cycle N → out_valid high in cycle N+1.
- Throughput: one push and one pop per cycle.
- out_product/out_class stable while out_valid & ~out_ready.
- Flags and nan_cnt reflect a push from cycle N at cycle N+1.

## Configuration
- FP16_RESBUF_BYPASS_EN defined: when count==0, out_valid=in_valid and out_product/out_class driven combinationally from in_product; if out_ready also high the product bypasses storage (count stays 0). Flags/nan_cnt still update. Zero-cycle latency when empty.
- Undefined: no combinational in→out path; minimum latency 1 cycle as above.

## Test plan
- Reset, then push 16'h3C00 with out_ready=1 → next cycle out_valid=1, out_product=16'h3C00, out_class=2, flags 0, count returns to 0.
- out_ready=0, push DEPTH products 16'h0001,16'h0002,… → in_ready=0 after DEPTH pushes, count=DEPTH, out_class=1; drain → values in order, pointer wrap verified by a second fill.
- Push 16'hFFFF, 16'hFDFF, 16'h7C00, 16'h0000 → classes 4,5,3,0; sticky_nan=sticky_inf=sticky_uf=1, nan_cnt=2.
- Assert flag_clr together with a push of 16'hFFFF → sticky_nan=1, nan_cnt=1, sticky_inf=0.
- CNT_W=2, push 5 NaNs → nan_cnt saturates at 3.
- Fill 3 entries, assert rst one cycle → count=0, out_valid=0, in_ready=1 next cycle; with FP16_RESBUF_BYPASS_EN, empty push with out_ready=1 appears on out_product same cycle.
